// File: rtl/bcd_mult_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mult_seq_pkg
//  Description : Shared types and BCD helper functions for the multi-digit
//                BCD multiplier sequencer (digit type, FSM state encoding,
//                digit validity test, single-digit decimal add, 0..81 binary
//                to two-digit BCD conversion).
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_mult_seq_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= 4'd9);
    endfunction

    // Returns {carry_out, digit}. A raw sum above 9 gets the +6 correction,
    // which both wraps the digit into 0..9 and sets bit 4 as the carry.
    function automatic logic [4:0] bcd_add_digit(input bcd_digit_t a,
                                                 input bcd_digit_t b,
                                                 input logic       cin);
        logic [4:0] s;
        s = 5'(a) + 5'(b) + 5'(cin);
        if (s > 5'd9) begin
            s = s + 5'd6;
        end
        return s;
    endfunction

    // Binary value 0..81 (a digit product) to {tens, ones}. Eight
    // conditional subtractions of ten cover the whole range.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] p);
        logic [6:0] r;
        logic [3:0] t;
        r = p;
        t = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, 4'b0000} | {1'b0, r};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mult_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mult_seq_if
//  Description : Operand/result handshake bundle of the BCD multiplier.
//                master = operand source / result sink, slave = sequencer.
//                in_valid/in_ready/dataa/datab : operand handshake
//                abort                         : cancel current operation
//                result_valid/result_ready     : result handshake
//                result/result_err             : BCD product / bad operand flag
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_mult_seq_if #(
    parameter int DIGITS = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   dataa;
    logic [4*DIGITS-1:0]   datab;
    logic                  abort;
    logic                  result_valid;
    logic                  result_ready;
    logic [8*DIGITS-1:0]   result;
    logic                  result_err;

    modport master (
        output in_valid, dataa, datab, abort, result_ready,
        input  in_ready, result_valid, result, result_err
    );

    modport slave (
        input  in_valid, dataa, datab, abort, result_ready,
        output in_ready, result_valid, result, result_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_acc.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_acc
//  Description : Combinational 2*DIGITS-digit BCD adder: accumulator plus a
//                two-digit product placed i_shift digits up.
//                i_acc, i_prod, i_shift -> o_sum.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_acc
    import bcd_mult_seq_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int SW     = 3
) (
    input  wire  [8*DIGITS-1:0] i_acc,
    input  wire  [7:0]          i_prod,
    input  wire  [SW-1:0]       i_shift,
    output logic [8*DIGITS-1:0] o_sum
);
    logic [8*DIGITS-1:0] w_addend;
    logic [4:0]          w_d;
    logic                w_c;

    assign w_addend = {{(8*DIGITS-8){1'b0}}, i_prod} << {i_shift, 2'b00};

    // Ripple the decimal carry through every digit; the product of two
    // DIGITS-digit numbers always fits, so the final carry is always zero.
    always_comb begin
        o_sum = '0;
        w_c   = 1'b0;
        w_d   = '0;
        for (int k = 0; k < 2*DIGITS; k++) begin
            w_d              = bcd_add_digit(i_acc[4*k +: 4], w_addend[4*k +: 4], w_c);
            o_sum[4*k +: 4]  = w_d[3:0];
            w_c              = w_d[4];
        end
    end
endmodule
`default_nettype wire

// File: rtl/bcd_mult.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mult
//  Description : Single-digit BCD multiplier, 4b x 4b -> 2-digit BCD,
//                two-cycle latency (operand register, product register).
//                clk, rst (sync, active-high flush), i_data_valid, i_a, i_b,
//                o_result_valid, o_result {tens, ones}.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mult
    import bcd_mult_seq_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    input  wire         i_data_valid,
    input  wire  [3:0]  i_a,
    input  wire  [3:0]  i_b,
    output logic        o_result_valid,
    output logic [7:0]  o_result
);
    bcd_digit_t r_a1, r_b1;
    logic       r_v1, r_v2;
    logic [7:0] r_prod;
    logic [6:0] w_bin;

    assign w_bin = 7'(r_a1) * 7'(r_b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a1   <= '0;
            r_b1   <= '0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_prod <= '0;
        end else begin
            r_a1   <= i_a;
            r_b1   <= i_b;
            r_v1   <= i_data_valid;
            r_v2   <= r_v1;
            r_prod <= bin_to_bcd2(w_bin);
        end
    end

    assign o_result_valid = r_v2;
    assign o_result       = r_prod;
endmodule
`default_nettype wire

// File: rtl/bcd_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mult_seq
//  Description : Multi-digit BCD multiplier sequencer. Feeds one digit pair
//                per cycle to a shared single-digit bcd_mult and accumulates
//                the shifted partial products in BCD.
//                clock, clock_areset_n (async active-low), bus (slave side of
//                bcd_mult_seq_if: operand, abort and result handshakes).
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mult_seq
    import bcd_mult_seq_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire            clock,
    input  wire            clock_areset_n,
    bcd_mult_seq_if.slave  bus
);
    localparam int IW = $clog2(DIGITS);
    localparam int SW = $clog2(2*DIGITS-1);
    localparam int AW = 8*DIGITS;

    state_t              r_state, w_next;
    logic [4*DIGITS-1:0] r_a, r_b;
    logic [IW-1:0]       r_i, r_j;
    logic                r_drain;
    logic [AW-1:0]       r_acc, w_acc_sum;
    logic                r_err;
    logic [1:0]          r_tag_v;
    logic [SW-1:0]       r_tag_sh0, r_tag_sh1;
    logic                w_accept, w_issue, w_bad, w_last, w_abort;
    logic [SW-1:0]       w_shift;
    bcd_digit_t          w_da, w_db;
    logic [7:0]          w_prod;
    logic                w_mult_valid_unused;

    assign w_abort = bus.abort && (r_state != IDLE);
    assign w_last  = (r_i == IW'(DIGITS-1)) && (r_j == IW'(DIGITS-1));
    assign w_shift = SW'(r_i) + SW'(r_j);
    assign w_da    = r_a[4*r_i +: 4];
    assign w_db    = r_b[4*r_j +: 4];

    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!is_bcd(bus.dataa[4*k +: 4]) || !is_bcd(bus.datab[4*k +: 4])) begin
                w_bad = 1'b1;
            end
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_issue  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_bad ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                w_issue = 1'b1;
                if (w_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next  = IDLE;
            w_issue = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath. r_tag_* follows each issued digit pair through the two
    // bcd_mult stages so the product is added with the shift it was issued at.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_drain   <= 1'b0;
            r_acc     <= '0;
            r_err     <= 1'b0;
            r_tag_v   <= '0;
            r_tag_sh0 <= '0;
            r_tag_sh1 <= '0;
        end else if (w_abort) begin
            r_i       <= '0;
            r_j       <= '0;
            r_drain   <= 1'b0;
            r_acc     <= '0;
            r_err     <= 1'b0;
            r_tag_v   <= '0;
        end else begin
            r_tag_v   <= {r_tag_v[0], w_issue};
            r_tag_sh0 <= w_shift;
            r_tag_sh1 <= r_tag_sh0;
            r_drain   <= (r_state == DRAIN) ? ~r_drain : 1'b0;
            if (r_tag_v[1]) begin
                r_acc <= w_acc_sum;
            end
            if (w_accept) begin
                r_a   <= bus.dataa;
                r_b   <= bus.datab;
                r_acc <= '0;
                r_err <= w_bad;
                r_i   <= '0;
                r_j   <= '0;
            end else if (w_issue) begin
                if (r_i == IW'(DIGITS-1)) begin
                    r_i <= '0;
                    r_j <= r_j + IW'(1);
                end else begin
                    r_i <= r_i + IW'(1);
                end
            end
        end
    end

    // The digit multiplier is held in reset while idle so no stale product
    // from an aborted operation can leak into the next one.
    bcd_mult u_mult (
        .clk            (clock),
        .rst            (r_state == IDLE),
        .i_data_valid   (w_issue),
        .i_a            (w_da),
        .i_b            (w_db),
        .o_result_valid (w_mult_valid_unused),
        .o_result       (w_prod)
    );

    bcd_acc #(
        .DIGITS (DIGITS),
        .SW     (SW)
    ) u_acc (
        .i_acc   (r_acc),
        .i_prod  (w_prod),
        .i_shift (r_tag_sh1),
        .o_sum   (w_acc_sum)
    );

    assign bus.in_ready     = (r_state == IDLE);
    assign bus.result_valid = (r_state == DONE);
    assign bus.result       = r_acc;
    assign bus.result_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bcd_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_mult_seq
//  Description : Scoreboard bench for bcd_mult_seq (DIGITS=4): directed
//                operand pairs with hand-computed products; a monitor pops
//                expectations whenever a result is presented.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_mult_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    bcd_mult_seq_if #(.DIGITS(4)) bus ();

    bcd_mult_seq #(.DIGITS(4)) dut (
        .clock          (clk),
        .clock_areset_n (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on the first cycle of each result, then checks that the
    // result stays stable while held and that in_ready returns after handshake.
    initial begin : monitor
        exp_t cur;
        logic prev_v  = 1'b0;
        logic chk_rdy = 1'b0;
        logic have    = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v  = 1'b0;
                chk_rdy = 1'b0;
            end else begin
                if (chk_rdy) begin
                    check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
                    chk_rdy = 1'b0;
                end
                if (bus.result_valid) begin
                    if (!prev_v) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            have = 1'b0;
                            $display("FAIL unexpected_result_valid: got result %h with nothing pending (cycle %0d)",
                                     bus.result, cyc);
                        end else begin
                            cur  = sb.pop_front();
                            have = 1'b1;
                            check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                        end
                    end
                    if (have) begin
                        check("result", bus.result, cur.res);
                        check("result_err", 32'(bus.result_err), 32'(cur.err));
                        check("in_ready_while_done", 32'(bus.in_ready), 32'd0);
                    end
                    if (bus.result_ready) chk_rdy = 1'b1;
                    prev_v = !bus.result_ready;
                end else begin
                    prev_v = 1'b0;
                end
            end
        end
    end

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic push,
                            input logic [31:0] res, input logic err, input int lat,
                            output int acc_cyc);
        int n;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.dataa    = a;
        bus.datab    = b;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        acc_cyc = cyc + 1;
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready %b required 1", bus.in_ready);
        end else if (push) begin
            sb.push_back('{res: res, err: err, lat: lat, acc: acc_cyc});
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.result_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || bus.result_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: pending %0d required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] res, input logic err, input int lat);
        int acc_c;
        start_op(a, b, 1'b1, res, err, lat, acc_c);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},     32'(bus.in_ready),     32'd1);
        check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        check({tag, "_result"},       bus.result,            32'd0);
        check({tag, "_result_err"},   32'(bus.result_err),   32'd0);
    endtask

    initial begin : driver
        int acc_c;
        int n;
        bus.in_valid     = 1'b0;
        bus.dataa        = '0;
        bus.datab        = '0;
        bus.abort        = 1'b0;
        bus.result_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run(16'h1234, 16'h5678, 32'h07006652, 1'b0, 19);
        run(16'h9999, 16'h9999, 32'h99980001, 1'b0, 19);
        run(16'h0000, 16'h9876, 32'h00000000, 1'b0, 19);
        run(16'h9000, 16'h0009, 32'h00081000, 1'b0, 19);
        run(16'h12A4, 16'h0001, 32'h00000000, 1'b1, 1);
        run(16'h0001, 16'h00F0, 32'h00000000, 1'b1, 1);
        run(16'h0021, 16'h0003, 32'h00000063, 1'b0, 19);

        // Downstream stall: result must hold for ten cycles.
        bus.result_ready = 1'b0;
        start_op(16'h1000, 16'h1000, 1'b1, 32'h01000000, 1'b0, 19, acc_c);
        n = 0;
        while (!bus.result_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.result_ready = 1'b1;
        wait_done();

        // Abort in cycle accept+7: nothing may come out.
        start_op(16'h4321, 16'h8765, 1'b0, 32'h0, 1'b0, 0, acc_c);
        while (cyc < acc_c + 6) begin
            @(posedge clk); #1;
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("in_ready_after_abort", 32'(bus.in_ready), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        run(16'h0021, 16'h0003, 32'h00000063, 1'b0, 19);

        // Asynchronous reset in the middle of ISSUE.
        start_op(16'h7777, 16'h3333, 1'b0, 32'h0, 1'b0, 0, acc_c);
        while (cyc < acc_c + 5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(16'h0005, 16'h0005, 32'h00000025, 1'b0, 19);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
